// File: rtl/uart_pkg.sv
// Shared UART constants and types.
// Used by the TX FIFO and the transmitter.
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int TX_FIFO_DEPTH = 16;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_LOAD   = 3'd1,
    TX_START  = 3'd2,
    TX_DATA   = 3'd3,
    TX_PARITY = 3'd4,
    TX_STOP   = 3'd5,
    TX_DELAY  = 3'd6
  } tx_state_e;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port array: one write port,
// one registered read port.
module uart_fifo_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage write; contents are not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; holds until next read.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between host writes and UART TX.
// Option UART_TX_FIFO_LEVEL_EN adds level/afull.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = TX_FIFO_DEPTH,
  parameter int AW    = 4,
  parameter int WIDTH = UART_DATA_W
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_n,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             overflow
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [AW:0]      level,
  output logic             afull
`endif
);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        wr_ok;
  logic        rd_ok;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign wr_ok = wr_en & ~full & ~flush;
  assign rd_ok = ~rd_n & ~empty & ~flush;

  // Pointer update; flush wins over traffic.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky overflow on a write while full.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)            overflow <= 1'b0;
    else if (flush)          overflow <= 1'b0;
    else if (wr_en && full)  overflow <= 1'b1;
  end

`ifdef UART_TX_FIFO_LEVEL_EN
  assign level = wr_ptr - rd_ptr;
  assign afull = (level >= (AW+1)'(DEPTH-2));
`endif

  uart_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (WIDTH)
  ) u_ram (
    .clk     (clk),
    .aresetn (aresetn),
    .clr     (flush),
    .we      (wr_ok),
    .waddr   (wr_ptr[AW-1:0]),
    .wdata   (wr_data),
    .re      (rd_ok),
    .raddr   (rd_ptr[AW-1:0]),
    .rdata   (rd_data)
  );

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo.
// Honours UART_TX_FIFO_LEVEL_EN if defined.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic       clk = 0;
  logic       aresetn = 0;
  logic       flush = 0;
  logic       wr_en = 0;
  logic [7:0] wr_data = '0;
  logic       rd_n = 1;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic       overflow;
`ifdef UART_TX_FIFO_LEVEL_EN
  logic [AW:0] level;
  logic        afull;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0] sb[$];
  logic [7:0] m_rd = '0;
  logic       m_ovf = 0;
  int         sent = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (8)
  ) dut (
    .clk      (clk),
    .aresetn  (aresetn),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_n     (rd_n),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .overflow (overflow)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .level    (level),
    .afull    (afull)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check("rd_data", 32'(rd_data), 32'(m_rd));
    check("empty", 32'(empty), 32'(sb.size() == 0));
    check("full", 32'(full), 32'(sb.size() == DEPTH));
    check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef UART_TX_FIFO_LEVEL_EN
    check("level", 32'(level), 32'(sb.size()));
    check("afull", 32'(afull),
          32'(sb.size() >= DEPTH - 2));
`endif
  endtask

  // One clock with optional write and read.
  task automatic step(input logic w,
                      input logic [7:0] d,
                      input logic r);
    logic wa, ra;
    wr_en   = w;
    wr_data = d;
    rd_n    = ~r;
    ra = r && (sb.size() != 0);
    wa = w && (sb.size() < DEPTH);
    if (w && !wa) m_ovf = 1'b1;
    @(posedge clk);
    if (ra) m_rd = sb.pop_front();
    if (wa) begin
      sb.push_back(d);
      sent++;
    end
    #1;
    wr_en = 0;
    rd_n  = 1;
    check_state();
  endtask

  task automatic drain();
    while (sb.size() != 0) step(0, 8'h00, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check_state();
    aresetn = 1;
    @(posedge clk);
    #1;

    // Three bytes in, three out.
    step(1, 8'h41, 0);
    step(1, 8'h42, 0);
    step(1, 8'h43, 0);
    repeat (3) step(0, 8'h00, 1);
    step(0, 8'h00, 1);

    // Fill, overflow, drain.
    for (int i = 0; i < DEPTH; i++)
      step(1, 8'(i), 0);
    step(1, 8'hFF, 0);
    drain();

    // Simultaneous write+read when full.
    for (int i = 0; i < DEPTH; i++)
      step(1, 8'(8'h80 + i), 0);
    step(1, 8'h55, 1);
    drain();

    // Simultaneous write+read when empty.
    step(1, 8'h66, 1);
    step(0, 8'h00, 1);
    check("rd66", 32'(rd_data), 32'h66);

    // Flush with 5 entries and traffic.
    for (int i = 0; i < 5; i++)
      step(1, 8'(8'h10 + i), 0);
    flush = 1;
    wr_en = 1;
    wr_data = 8'hAA;
    rd_n = 0;
    @(posedge clk);
    #1;
    flush = 0;
    wr_en = 0;
    rd_n = 1;
    sb.delete();
    m_rd = '0;
    m_ovf = 0;
    check_state();
    step(0, 8'h00, 1);

    // Interleaved traffic over pointer wraps.
    sent = 0;
    for (int i = 0; i < 200 && sent < 40; i++)
      step($urandom_range(0, 3) != 0,
           8'(sent + 8'hC0),
           $urandom_range(0, 2) != 0);
    drain();
    check("sent40", 32'(sent), 32'd40);

    // Async reset mid-stream.
    for (int i = 0; i < 4; i++)
      step(1, 8'(8'h20 + i), 0);
    step(0, 8'h00, 1);
    #2;
    aresetn = 0;
    #1;
    sb.delete();
    m_rd = '0;
    m_ovf = 0;
    check_state();
    @(negedge clk);
    aresetn = 1;
    @(posedge clk);
    #1;
    step(0, 8'h00, 1);
    step(1, 8'h77, 0);
    step(0, 8'h00, 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
